// File: rtl/ft64_pti_deframer_pkg.sv
// Shared types and constants for the PTI receive deframer: FSM states,
// output word layout and frame-counter helpers.
package ft64_pti_deframer_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_ABORT   = 3'd5
    } state_e;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
    localparam int         CNT_W        = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // 64 data bits plus 11 tag bits travel together through the output register.
    typedef struct packed {
        logic [7:0]  cmd;
        logic        sof;
        logic        last;
        logic        err;
        logic [63:0] dat;
    } word_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ft64_pti_deframer_if.sv
// Byte-in / word-out streaming bundle of the PTI deframer.
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both high; a producer keeps valid and its payload stable until that edge.
interface ft64_pti_deframer_if;

    logic        b_valid_i;
    logic        b_ready_o;
    logic [7:0]  b_dat_i;

    logic        w_valid_o;
    logic        w_ready_i;
    logic [63:0] w_dat_o;
    logic        w_sof_o;
    logic        w_last_o;
    logic        w_err_o;
    logic [7:0]  w_cmd_o;

    // master: the deframer itself
    modport master (
        input  b_valid_i, b_dat_i, w_ready_i,
        output b_ready_o, w_valid_o, w_dat_o, w_sof_o, w_last_o, w_err_o, w_cmd_o
    );

    // slave: the byte source and word sink around it
    modport slave (
        output b_valid_i, b_dat_i, w_ready_i,
        input  b_ready_o, w_valid_o, w_dat_o, w_sof_o, w_last_o, w_err_o, w_cmd_o
    );

endinterface

// File: rtl/ft64_pti_deframer_wordreg.sv
// Output holding register: a word can be loaded already valid, or loaded held
// (invisible) and released later with its final error flag.
module ft64_pti_deframer_wordreg
    import ft64_pti_deframer_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  load_vld_i,
    input  word_t load_word_i,
    input  logic  rel_i,
    input  logic  rel_err_i,
    input  logic  ready_i,
    output logic  valid_o,
    output logic  held_o,
    output word_t word_o
);

    logic  valid_q, valid_d;
    logic  held_q,  held_d;
    word_t word_q,  word_d;

    always_comb begin
        valid_d = valid_q;
        held_d  = held_q;
        word_d  = word_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A load in the same cycle as a take replaces the word without a bubble.
        if (load_i) begin
            word_d  = load_word_i;
            valid_d = load_vld_i;
            held_d  = ~load_vld_i;
        end else if (rel_i && held_q) begin
            word_d.err = rel_err_i;
            valid_d    = 1'b1;
            held_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign held_o  = held_q;
    assign word_o  = word_q;

endmodule

// File: rtl/ft64_pti_deframer.sv
// PTI receive deframer: hunts SOF, parses CMD/LEN/payload/CSUM, packs payload
// little-endian into 64-bit words, aborts stalled frames after an idle timeout.
module ft64_pti_deframer
    import ft64_pti_deframer_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEF,
    parameter int         TIMEOUT  = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ft64_pti_deframer_if.master pti_io,
    output logic [CNT_W-1:0]   frm_ok_o,
    output logic [CNT_W-1:0]   frm_bad_o,
    output state_e             dbg_state_o
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [55:0]        asm_q, asm_d;
    logic               emitted_q, emitted_d;
    logic               ab_loaded_q, ab_loaded_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]   ok_q, ok_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic  wr_valid, wr_held;
    word_t wr_word;
    logic  ld, ld_vld, rel, rel_err;
    word_t ld_word, abort_word;
    logic  ok_inc, bad_inc;

    logic  b_ready, b_acc, w_take, occupied, wr_free;
    logic  in_frame, counting, timeout;

    assign w_take   = wr_valid & pti_io.w_ready_i;
    assign wr_free  = ~(wr_valid & ~pti_io.w_ready_i);
    assign occupied = (wr_valid & ~pti_io.w_ready_i) | wr_held;

    always_comb begin
        b_ready = 1'b1;
        if (state_q == ST_PAYLOAD && idx_q == 3'd7 && occupied) begin
            b_ready = 1'b0;
        end
        if (state_q == ST_ABORT) begin
            b_ready = 1'b0;
        end
    end

    assign b_acc    = pti_io.b_valid_i & b_ready;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    // Output back-pressure holds b_ready low, which keeps the idle counter frozen.
    assign counting = in_frame & ~b_acc & b_ready;
    assign timeout  = counting & (idle_q == IDLE_LAST);

    always_comb begin
        if (!in_frame || b_acc || timeout) begin
            idle_d = '0;
        end else if (counting) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        sum_d       = sum_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        emitted_d   = emitted_q;
        ab_loaded_d = ab_loaded_q;
        ok_inc      = 1'b0;
        bad_inc     = 1'b0;
        ld          = 1'b0;
        ld_vld      = 1'b0;
        ld_word     = '0;
        rel         = 1'b0;
        rel_err     = 1'b0;
        abort_word  = {cmd_q, ~emitted_q, 1'b1, 1'b1, 64'd0};

        case (state_q)
            ST_HUNT: begin
                if (b_acc && pti_io.b_dat_i == SOF_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (b_acc) begin
                    cmd_d   = pti_io.b_dat_i;
                    sum_d   = pti_io.b_dat_i;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (b_acc) begin
                    sum_d = sum_q + pti_io.b_dat_i;
                    if (pti_io.b_dat_i == 8'd0) begin
                        bad_inc = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        wcnt_d    = pti_io.b_dat_i;
                        idx_d     = 3'd0;
                        emitted_d = 1'b0;
                        state_d   = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (b_acc) begin
                    sum_d = sum_q + pti_io.b_dat_i;
                    asm_d = {pti_io.b_dat_i, asm_q[55:8]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        ld              = 1'b1;
                        ld_word.cmd     = cmd_q;
                        ld_word.sof     = ~emitted_q;
                        ld_word.last    = (wcnt_q == 8'd1);
                        ld_word.dat     = {pti_io.b_dat_i, asm_q};
                        if (wcnt_q == 8'd1) begin
                            // Final word waits invisible until its checksum is known.
                            ld_vld  = 1'b0;
                            state_d = ST_CSUM;
                        end else begin
                            ld_vld    = 1'b1;
                            emitted_d = 1'b1;
                            wcnt_d    = wcnt_q - 8'd1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (b_acc) begin
                    rel     = 1'b1;
                    rel_err = (pti_io.b_dat_i != sum_q);
                    ok_inc  = (pti_io.b_dat_i == sum_q);
                    bad_inc = (pti_io.b_dat_i != sum_q);
                    state_d = ST_HUNT;
                end
            end
            ST_ABORT: begin
                if (!ab_loaded_q) begin
                    if (wr_free) begin
                        ld          = 1'b1;
                        ld_vld      = 1'b1;
                        ld_word     = abort_word;
                        ab_loaded_d = 1'b1;
                    end
                end else if (w_take) begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (timeout) begin
            bad_inc = 1'b1;
            idx_d   = 3'd0;
            if (emitted_q || wr_held) begin
                state_d     = ST_ABORT;
                ld          = wr_free;
                ld_vld      = 1'b1;
                ld_word     = abort_word;
                ab_loaded_d = wr_free;
            end else begin
                state_d = ST_HUNT;
            end
        end
    end

    assign ok_d  = ok_inc  ? sat_inc(ok_q)  : ok_q;
    assign bad_d = bad_inc ? sat_inc(bad_q) : bad_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HUNT;
            cmd_q       <= '0;
            sum_q       <= '0;
            wcnt_q      <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            emitted_q   <= 1'b0;
            ab_loaded_q <= 1'b0;
            idle_q      <= '0;
            ok_q        <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sum_q       <= sum_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            emitted_q   <= emitted_d;
            ab_loaded_q <= ab_loaded_d;
            idle_q      <= idle_d;
            ok_q        <= ok_d;
            bad_q       <= bad_d;
        end
    end

    ft64_pti_deframer_wordreg u_wordreg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ld),
        .load_vld_i  (ld_vld),
        .load_word_i (ld_word),
        .rel_i       (rel),
        .rel_err_i   (rel_err),
        .ready_i     (pti_io.w_ready_i),
        .valid_o     (wr_valid),
        .held_o      (wr_held),
        .word_o      (wr_word)
    );

    assign pti_io.b_ready_o = b_ready;
    assign pti_io.w_valid_o = wr_valid;
    assign pti_io.w_dat_o   = wr_word.dat;
    assign pti_io.w_sof_o   = wr_word.sof;
    assign pti_io.w_last_o  = wr_word.last;
    assign pti_io.w_err_o   = wr_word.err;
    assign pti_io.w_cmd_o   = wr_word.cmd;

    assign frm_ok_o    = ok_q;
    assign frm_bad_o   = bad_q;
    assign dbg_state_o = state_q;

endmodule
